// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_sequencer : multi-cycle control FSM for the 8-bit CPU        rev 1.0
// ============================================================================
module cpu_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             dec_ip,
   input  logic             dec_op,
   input  logic             dec_load,
   input  logic             dec_add,
   input  logic             dec_jump,
   input  logic             dec_jumpz,
   input  logic             dec_jumpnz,
   input  logic             dec_jumpc,
   input  logic             dec_jumpnc,
   input  logic             dec_sub,
   input  logic             dec_bitand,
   input  logic             alu_zero,
   input  logic             alu_carry,
   input  logic             mem_ack,
   input  logic             in_valid,
   input  logic             out_ready,
   output logic             mem_req,
   output logic             ir_load,
   output logic             arg_load,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             acc_load,
   output logic [2:0]       acc_sel,
   output logic             in_ready,
   output logic             out_valid,
   output logic             flag_z,
   output logic             flag_c,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ARG    = 3'd3,
      S_EXEC   = 3'd4,
      S_IN     = 3'd5,
      S_OUT    = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   localparam logic [2:0] SEL_ARG = 3'd0;
   localparam logic [2:0] SEL_ADD = 3'd1;
   localparam logic [2:0] SEL_SUB = 3'd2;
   localparam logic [2:0] SEL_AND = 3'd3;
   localparam logic [2:0] SEL_IN  = 3'd4;

   state_t      state_q;
   state_t      state_d;
   logic        flag_upd;
   logic        illegal_set;
   logic        retire;
   logic [10:0] dec_vec;

   assign dec_vec = {dec_bitand, dec_sub, dec_jumpnc, dec_jumpc, dec_jumpnz,
                     dec_jumpz, dec_jump, dec_add, dec_load, dec_op, dec_ip};
   assign state   = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         state_q <= state_d;
         if (flag_upd) begin
            flag_z <= alu_zero;
            flag_c <= alu_carry;
         end
         if (illegal_set) begin
            illegal <= 1'b1;
         end
         if (retire) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      ir_load     = 1'b0;
      arg_load    = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      acc_load    = 1'b0;
      acc_sel     = SEL_ARG;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      flag_upd    = 1'b0;
      illegal_set = 1'b0;
      retire      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!$onehot(dec_vec)) begin
               illegal_set = 1'b1;
               state_d     = S_ERROR;
            end else if (dec_ip) begin
               state_d = S_IN;
            end else if (dec_op) begin
               state_d = S_OUT;
            end else begin
               state_d = S_ARG;
            end
         end
         S_ARG: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               arg_load = 1'b1;
               pc_inc   = 1'b1;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            retire  = 1'b1;
            state_d = S_FETCH;
            // IR is still stable here, so the strobes select the operation directly
            if (dec_load) begin
               acc_load = 1'b1;
            end else if (dec_add) begin
               acc_load = 1'b1;
               acc_sel  = SEL_ADD;
               flag_upd = 1'b1;
            end else if (dec_sub) begin
               acc_load = 1'b1;
               acc_sel  = SEL_SUB;
               flag_upd = 1'b1;
            end else if (dec_bitand) begin
               acc_load = 1'b1;
               acc_sel  = SEL_AND;
               flag_upd = 1'b1;
            end else if (dec_jump) begin
               pc_load = 1'b1;
            end else if (dec_jumpz) begin
               pc_load = flag_z;
            end else if (dec_jumpnz) begin
               pc_load = !flag_z;
            end else if (dec_jumpc) begin
               pc_load = flag_c;
            end else if (dec_jumpnc) begin
               pc_load = !flag_c;
            end
         end
         S_IN: begin
            in_ready = 1'b1;
            acc_sel  = SEL_IN;
            if (in_valid) begin
               acc_load = 1'b1;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_ERROR;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_sequencer : table vectors, corner sequences and random vs. model
// ============================================================================
module tb_cpu_sequencer;

   localparam int OP_IP = 0, OP_OP = 1, OP_LOAD = 2, OP_ADD = 3, OP_JUMP = 4,
                  OP_JZ = 5, OP_JNZ = 6, OP_JC = 7, OP_JNC = 8, OP_SUB = 9, OP_AND = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [10:0] dec_v = '0;
   logic        alu_zero = 1'b0, alu_carry = 1'b0, mem_ack = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        mem_req, ir_load, arg_load, pc_inc, pc_load, acc_load;
   logic [2:0]  acc_sel;
   logic        in_ready, out_valid, flag_z, flag_c, illegal;
   logic [7:0]  retired;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;

   cpu_sequencer #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .dec_ip(dec_v[0]), .dec_op(dec_v[1]), .dec_load(dec_v[2]), .dec_add(dec_v[3]),
      .dec_jump(dec_v[4]), .dec_jumpz(dec_v[5]), .dec_jumpnz(dec_v[6]), .dec_jumpc(dec_v[7]),
      .dec_jumpnc(dec_v[8]), .dec_sub(dec_v[9]), .dec_bitand(dec_v[10]),
      .alu_zero(alu_zero), .alu_carry(alu_carry), .mem_ack(mem_ack),
      .in_valid(in_valid), .out_ready(out_ready),
      .mem_req(mem_req), .ir_load(ir_load), .arg_load(arg_load), .pc_inc(pc_inc),
      .pc_load(pc_load), .acc_load(acc_load), .acc_sel(acc_sel), .in_ready(in_ready),
      .out_valid(out_valid), .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal),
      .retired(retired), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference model: evaluated mid-cycle, when inputs are stable for the coming edge.
   logic [2:0] m_st = 3'd0;
   logic       m_z = 1'b0, m_c = 1'b0, m_ill = 1'b0;
   logic [7:0] m_ret = 8'd0;

   always @(negedge clk) begin : model
      logic [2:0] cs, ns, e_sel;
      logic       cz, cc, cill, nz, nc, nill;
      logic       e_req, e_ir, e_arg, e_inc, e_pcl, e_accl, e_rdy, e_ov;
      logic [7:0] cret, nret;
      int         op;
      cs   = rst_n ? m_st : 3'd0;
      cz   = rst_n ? m_z : 1'b0;
      cc   = rst_n ? m_c : 1'b0;
      cill = rst_n ? m_ill : 1'b0;
      cret = rst_n ? m_ret : 8'd0;
      ns = cs; nz = cz; nc = cc; nill = cill; nret = cret;
      {e_req, e_ir, e_arg, e_inc, e_pcl, e_accl, e_rdy, e_ov} = '0;
      e_sel = 3'd0;
      op = -1;
      for (int k = 0; k < 11; k++) if (dec_v[k]) op = k;
      case (cs)
         3'd0: if (run) ns = 3'd1;
         3'd1: begin
            e_req = 1'b1;
            if (mem_ack) begin e_ir = 1'b1; e_inc = 1'b1; ns = 3'd2; end
         end
         3'd2: begin
            if ($countones(dec_v) != 1) begin nill = 1'b1; ns = 3'd7; end
            else if (op == OP_IP) ns = 3'd5;
            else if (op == OP_OP) ns = 3'd6;
            else ns = 3'd3;
         end
         3'd3: begin
            e_req = 1'b1;
            if (mem_ack) begin e_arg = 1'b1; e_inc = 1'b1; ns = 3'd4; end
         end
         3'd4: begin
            ns = 3'd1;
            nret = cret + 8'd1;
            case (op)
               OP_LOAD: e_accl = 1'b1;
               OP_ADD, OP_SUB, OP_AND: begin
                  e_accl = 1'b1;
                  e_sel  = (op == OP_ADD) ? 3'd1 : (op == OP_SUB) ? 3'd2 : 3'd3;
                  nz = alu_zero; nc = alu_carry;
               end
               OP_JUMP: e_pcl = 1'b1;
               OP_JZ:   e_pcl = cz;
               OP_JNZ:  e_pcl = !cz;
               OP_JC:   e_pcl = cc;
               OP_JNC:  e_pcl = !cc;
               default: ;
            endcase
         end
         3'd5: begin
            e_rdy = 1'b1; e_sel = 3'd4;
            if (in_valid) begin e_accl = 1'b1; nret = cret + 8'd1; ns = 3'd1; end
         end
         3'd6: begin
            e_ov = 1'b1;
            if (out_ready) begin nret = cret + 8'd1; ns = 3'd1; end
         end
         default: ;
      endcase
      check("model_cycle",
            {7'd0, mem_req, ir_load, arg_load, pc_inc, pc_load, acc_load, acc_sel,
             in_ready, out_valid, flag_z, flag_c, illegal, retired, state},
            {7'd0, e_req, e_ir, e_arg, e_inc, e_pcl, e_accl, e_sel,
             e_rdy, e_ov, cz, cc, cill, cret, cs});
      if (rst_n) begin
         m_st <= ns; m_z <= nz; m_c <= nc; m_ill <= nill; m_ret <= nret;
      end else begin
         m_st <= 3'd0; m_z <= 1'b0; m_c <= 1'b0; m_ill <= 1'b0; m_ret <= 8'd0;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; run = 1'b0; dec_v = '0; mem_ack = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Runs one instruction with all handshakes ready; captures the completing cycle.
   task automatic run_instr(input int op, input logic z, input logic c,
                            output logic [4:0] obs, output logic [1:0] fl,
                            output logic [7:0] dret);
      logic [7:0] r0;
      logic       got;
      r0 = retired; got = 1'b0; obs = '0;
      dec_v = 11'(1) << op; alu_zero = z; alu_carry = c;
      mem_ack = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (state == 3'd4 || state == 3'd5 || state == 3'd6) begin
            obs = {acc_load, acc_sel, pc_load};
            got = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!got) check("instr_timeout", 32'd0, 32'd1);
      fl = {flag_z, flag_c};
      dret = retired - r0;
   endtask

   typedef struct {
      int         op;
      logic       z;
      logic       c;
      logic [4:0] exp_obs;   // {acc_load, acc_sel, pc_load}
      logic [1:0] exp_fl;    // {flag_z, flag_c} after the instruction
   } vec_t;

   vec_t tbl[17];

   initial begin
      logic [17:0] st_hist;
      logic [5:0]  inc_hist, ld_hist;
      logic [4:0]  obs;
      logic [1:0]  fl;
      logic [7:0]  dret, r0;
      logic [10:0] cur;
      logic        done;
      int          n5, nrdy, nld, nv, n6, w1, w3, nreq, nir, narg, ninc, st;
      logic [9:0]  strobes;

      tbl[0]  = '{OP_LOAD, 1'b0, 1'b0, 5'b1_000_0, 2'b00};
      tbl[1]  = '{OP_ADD,  1'b1, 1'b1, 5'b1_001_0, 2'b11};
      tbl[2]  = '{OP_JNZ,  1'b0, 1'b0, 5'b0_000_0, 2'b11};
      tbl[3]  = '{OP_JC,   1'b0, 1'b0, 5'b0_000_1, 2'b11};
      tbl[4]  = '{OP_JZ,   1'b0, 1'b0, 5'b0_000_1, 2'b11};
      tbl[5]  = '{OP_JNC,  1'b0, 1'b0, 5'b0_000_0, 2'b11};
      tbl[6]  = '{OP_SUB,  1'b0, 1'b1, 5'b1_010_0, 2'b01};
      tbl[7]  = '{OP_JZ,   1'b1, 1'b0, 5'b0_000_0, 2'b01};
      tbl[8]  = '{OP_JNZ,  1'b0, 1'b0, 5'b0_000_1, 2'b01};
      tbl[9]  = '{OP_AND,  1'b0, 1'b0, 5'b1_011_0, 2'b00};
      tbl[10] = '{OP_JC,   1'b1, 1'b1, 5'b0_000_0, 2'b00};
      tbl[11] = '{OP_JNC,  1'b0, 1'b0, 5'b0_000_1, 2'b00};
      tbl[12] = '{OP_JUMP, 1'b0, 1'b0, 5'b0_000_1, 2'b00};
      tbl[13] = '{OP_LOAD, 1'b1, 1'b1, 5'b1_000_0, 2'b00};
      tbl[14] = '{OP_IP,   1'b0, 1'b0, 5'b1_100_0, 2'b00};
      tbl[15] = '{OP_OP,   1'b0, 1'b0, 5'b0_000_0, 2'b00};
      tbl[16] = '{OP_JZ,   1'b1, 1'b0, 5'b0_000_0, 2'b00};

      // LOAD from reset: state walk, pc_inc and acc_load timing
      do_reset();
      run = 1'b1; mem_ack = 1'b1; dec_v = 11'(1) << OP_LOAD;
      st_hist = '0; inc_hist = '0; ld_hist = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0)
            check("reset_state", {mem_req, ir_load, arg_load, pc_inc, pc_load, acc_load,
                  acc_sel, in_ready, out_valid, flag_z, flag_c, illegal, retired, state}, 32'd0);
         st_hist  = {st_hist[14:0], state};
         inc_hist = {inc_hist[4:0], pc_inc};
         ld_hist  = {ld_hist[4:0], acc_load};
         @(posedge clk);
         #1;
      end
      run = 1'b0;
      check("load_states", 32'(st_hist), 32'(18'b000_001_010_011_100_001));
      check("load_pc_inc", 32'(inc_hist), 32'(6'b010101));
      check("load_acc_load", 32'(ld_hist), 32'(6'b000010));
      check("load_retired", 32'(retired), 32'd1);

      // Table of back-to-back instructions; flags carry from row to row
      foreach (tbl[i]) begin
         run_instr(tbl[i].op, tbl[i].z, tbl[i].c, obs, fl, dret);
         check($sformatf("tbl%0d_exec", i), 32'(obs), 32'(tbl[i].exp_obs));
         check($sformatf("tbl%0d_flags", i), 32'(fl), 32'(tbl[i].exp_fl));
         check($sformatf("tbl%0d_retire", i), 32'(dret), 32'd1);
      end

      // IN waits 5 cycles for in_valid
      dec_v = 11'(1) << OP_IP; in_valid = 1'b0; mem_ack = 1'b1;
      n5 = 0; nrdy = 0; nld = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         nrdy += int'(in_ready); nld += int'(acc_load);
         if (state == 3'd5) n5++;
         @(posedge clk);
         #1;
         if (n5 == 5) break;
      end
      check("in_wait", {n5[7:0], nrdy[7:0], nld[7:0]}, {8'd5, 8'd5, 8'd0});
      in_valid = 1'b1;
      @(negedge clk);
      check("in_accept", 32'({in_ready, acc_load, acc_sel}), 32'(5'b1_1_100));
      @(posedge clk);
      #1;
      check("in_to_fetch", 32'(state), 32'd1);

      // OUT with out_ready low for 3 cycles
      dec_v = 11'(1) << OP_OP; out_ready = 1'b0; r0 = retired;
      nv = 0; n6 = 0; done = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         nv += int'(out_valid);
         if (state == 3'd6) n6++;
         @(posedge clk);
         #1;
         if (n6 == 3) out_ready = 1'b1;
         if (n6 >= 4 && state == 3'd1) begin done = 1'b1; break; end
      end
      check("out_done", 32'(done), 32'd1);
      check("out_valid_cycles", 32'(nv), 32'd4);
      check("out_retire", 32'(8'(retired - r0)), 32'd1);

      // mem_ack delayed 3 cycles in both FETCH and ARG
      dec_v = 11'(1) << OP_LOAD;
      w1 = 0; w3 = 0; nreq = 0; nir = 0; narg = 0; ninc = 0; done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         mem_ack = (state == 3'd1 && w1 == 3) || (state == 3'd3 && w3 == 3);
         @(negedge clk);
         nreq += int'(mem_req); nir += int'(ir_load);
         narg += int'(arg_load); ninc += int'(pc_inc);
         if (state == 3'd1) w1++;
         if (state == 3'd3) w3++;
         @(posedge clk);
         #1;
         if (state == 3'd4) begin done = 1'b1; break; end
      end
      check("slow_mem_done", 32'(done), 32'd1);
      check("slow_mem_counts", {nreq[7:0], nir[7:0], narg[7:0], ninc[7:0]},
            {8'd8, 8'd1, 8'd1, 8'd2});
      mem_ack = 1'b1;
      @(posedge clk);
      #1;

      // Two strobes in DECODE: ERROR, sticky, silent
      dec_v = (11'(1) << OP_ADD) | (11'(1) << OP_SUB);
      for (int k = 0; k < 6 && state != 3'd7; k++) begin
         @(posedge clk);
         #1;
      end
      check("illegal_two", 32'({illegal, state}), 32'(4'b1_111));
      run = 1'b1; in_valid = 1'b1; out_ready = 1'b1; strobes = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         strobes |= {mem_req, ir_load, arg_load, pc_inc, pc_load, acc_load, acc_sel,
                     in_ready, out_valid} & 10'h3FF;
         @(posedge clk);
         #1;
      end
      check("error_silent", 32'({strobes, illegal, state}), 32'(14'b0_1_111));

      // No strobes in DECODE
      do_reset();
      run = 1'b1; mem_ack = 1'b1; dec_v = '0;
      for (int k = 0; k < 6 && state != 3'd7; k++) begin
         @(posedge clk);
         #1;
      end
      check("illegal_none", 32'({illegal, state}), 32'(4'b1_111));

      // Reset mid-ARG after flags and retired were set
      do_reset();
      run = 1'b1;
      run_instr(OP_ADD, 1'b1, 1'b1, obs, fl, dret);
      check("pre_reset_flags", 32'({fl, retired}), 32'({2'b11, 8'd1}));
      dec_v = 11'(1) << OP_LOAD; mem_ack = 1'b1;
      for (int k = 0; k < 6 && state != 3'd3; k++) begin
         if (state == 3'd2) mem_ack = 1'b0;
         @(posedge clk);
         #1;
      end
      mem_ack = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", {mem_req, ir_load, arg_load, pc_inc, pc_load, acc_load, acc_sel,
            in_ready, out_valid, flag_z, flag_c, illegal, retired, state}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Random traffic against the model; decoder noise outside DECODE/EXEC
      cur = 11'(1) << OP_LOAD;
      for (int n = 0; n < 4000; n++) begin
         st = int'(state);
         run       = 1'($urandom);
         mem_ack   = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 2) == 0);
         out_ready = ($urandom_range(0, 2) == 0);
         alu_zero  = 1'($urandom);
         alu_carry = 1'($urandom);
         if (st == 2) begin
            if ($urandom_range(0, 99) == 0) begin
               cur = 11'($urandom);
               if ($countones(cur) == 1) cur = 11'h003;
            end else begin
               cur = 11'(1) << $urandom_range(0, 10);
            end
         end
         dec_v = (st == 2 || st == 4) ? cur : 11'($urandom);
         if (st == 7 || $urandom_range(0, 299) == 0) rst_n = 1'b0;
         @(posedge clk);
         #1 rst_n = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
